// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for alu_issue_ctrl: ALU selects, FSM states, instruction
// field positions and flag-vector bit indices.
package alu_issue_ctrl_pkg;

  localparam int unsigned IW = 10;
  localparam int unsigned AW = 2;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_XOR = 2'b10;
  localparam logic [1:0] SEL_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Field LSB positions; 2-bit fields unless noted.
  localparam int unsigned INSTR_LDI = 9;
  localparam int unsigned SEL_LSB   = 7;
  localparam int unsigned RD_LSB    = 5;
  localparam int unsigned RS1_LSB   = 3;
  localparam int unsigned RS2_LSB   = 1;
  localparam int unsigned IMM_LSB   = 0;

  // flags = {carry, zero, ovf}
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic [1:0] field2(input logic [IW-1:0] ins, input int unsigned lsb);
    return ins[lsb +: 2];
  endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// Register file for alu_issue_ctrl: two operand read ports, one write port and
// a combinational debug read port. Cleared by asynchronous reset.
module alu_issue_rf #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned DW    = 4,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem_q [NREGS];
  logic [DW-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a  = mem_q[raddr_a];
  assign rdata_b  = mem_q[raddr_b];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back front-end for the 4-bit ALU: IDLE -> EXEC -> WB per instruction.
// Optional STICKY_OVF_EN enables the sticky overflow bit with synchronous clear.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 4,
  parameter int unsigned DW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,
  input  logic          alu_ovf,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [2:0]    flags,
  output logic          ovf_sticky,
  input  logic          ovf_clr,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [DW-1:0] hold_res_q, hold_res_d;
  logic [2:0]    hold_flg_q, hold_flg_d;
  logic [2:0]    flags_q, flags_d;
  logic [DW-1:0] res_data_q, res_data_d;

  logic          is_ldi;
  logic [DW-1:0] imm;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;

  assign is_ldi = instr_q[INSTR_LDI];
  assign imm    = instr_q[IMM_LSB +: DW];

  alu_issue_rf #(
    .NREGS (NREGS),
    .DW    (DW),
    .AW    (AW)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (field2(instr_q, RD_LSB)),
    .wdata    (rf_wdata),
    .raddr_a  (field2(instr_q, RS1_LSB)),
    .rdata_a  (rs1_data),
    .raddr_b  (field2(instr_q, RS2_LSB)),
    .rdata_b  (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    hold_res_d  = hold_res_q;
    hold_flg_d  = hold_flg_q;
    flags_d     = flags_q;
    res_data_d  = res_data_q;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = SEL_AND;
    rf_we       = 1'b0;
    rf_wdata    = is_ldi ? imm : hold_res_q;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!is_ldi) begin
          alu_a   = rs1_data;
          alu_b   = rs2_data;
          alu_sel = field2(instr_q, SEL_LSB);
        end
        // LDI captures a don't-care result; it is never written back.
        hold_res_d = alu_out;
        hold_flg_d = {alu_carry, alu_zero, alu_ovf};
        state_d    = ST_WB;
      end
      ST_WB: begin
        res_valid  = 1'b1;
        rf_we      = 1'b1;
        res_data_d = rf_wdata;
        if (!is_ldi) begin
          flags_d = hold_flg_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      hold_res_q <= '0;
      hold_flg_q <= '0;
      flags_q    <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      hold_res_q <= hold_res_d;
      hold_flg_q <= hold_flg_d;
      flags_q    <= flags_d;
      res_data_q <= res_data_d;
    end
  end

  assign flags    = flags_q;
  assign res_data = res_data_q;

`ifdef STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set takes priority over a coincident clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr) begin
      sticky_d = 1'b0;
    end
    if (state_q == ST_WB && !is_ldi && hold_flg_q[FLAG_V]) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule
